// File: rtl/qpix_top.sv
// QPix event collector: 17 synchronised hit lines, window FSM, per-channel
// pending latches, lowest-index arbiter and a first-word fall-through event FIFO.
module qpix_top #(
  parameter int FIFO_DEPTH = 128,
  parameter int TS_W       = 27
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [15:0]   oLVDS,
  input  logic          opad2_deltaT,
  input  logic [2047:0] reg_rw,
  output logic [31:0]   fifo_dout,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [7:0]    fifo_count,
  output logic          window_active,
  output logic [15:0]   overflow_cnt
);

  localparam int NCH = 17;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WINDOW} state_t;

  function automatic logic [4:0] count_ones(input logic [NCH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic        rst;
  logic        trig_bit, rd_bit, sow;
  logic [31:0] win_width, width_m1;
  logic [15:0] win_wait;
  logic        unused_bits;

  assign rst         = !resetn || reg_rw[0];
  assign trig_bit    = reg_rw[15];
  assign rd_bit      = reg_rw[6*32];
  assign win_width   = reg_rw[7*32 +: 32];
  assign sow         = reg_rw[9*32+31];
  assign win_wait    = reg_rw[9*32 +: 16];
  assign width_m1    = (win_width == 32'd0) ? 32'd0 : win_width - 32'd1;
  assign unused_bits = ^reg_rw;

  // Stage p0/p1: two-flop synchroniser; p2: previous value for edge detect
  logic [NCH-1:0] sync_p0, sync_p1, prev_p2, hit_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      sync_p0 <= {opad2_deltaT, oLVDS};
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign hit_p2 = sync_p1 & ~prev_p2;

  state_t      state, state_nxt;
  logic [31:0] wcnt, wcnt_nxt;
  logic        trig_prev, rd_prev, trig_rise;

  assign trig_rise = trig_bit & ~trig_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      trig_prev <= 1'b0;
      rd_prev   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      trig_prev <= trig_bit;
      rd_prev   <= rd_bit;
    end
  end

  // wcnt holds the remaining cycles minus one of the current WAIT/WINDOW phase
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE: begin
        if (trig_rise) begin
          if (win_wait == 16'd0) begin
            state_nxt = S_WINDOW;
            wcnt_nxt  = width_m1;
          end else begin
            state_nxt = S_WAIT;
            wcnt_nxt  = 32'(win_wait) - 32'd1;
          end
        end
      end
      S_WAIT: begin
        if (wcnt == 32'd0) begin
          state_nxt = S_WINDOW;
          wcnt_nxt  = width_m1;
        end else begin
          wcnt_nxt = wcnt - 32'd1;
        end
      end
      S_WINDOW: begin
        if (wcnt == 32'd0) state_nxt = S_IDLE;
        else               wcnt_nxt  = wcnt - 32'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign window_active = (state == S_WINDOW);

  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      ts_cnt <= '0;
    else if (sow && state != S_WINDOW && state_nxt == S_WINDOW)
      ts_cnt <= '0;
    else if (!sow || state == S_WINDOW)
      ts_cnt <= ts_cnt + 1'b1;
  end

  logic [NCH-1:0]  cap, pend, grant_mask;
  logic [TS_W-1:0] pend_ts [NCH];
  logic [4:0]      grant_ch;
  logic            grant_vld, push, pop;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     mem [FIFO_DEPTH];

  assign cap = hit_p2 & {NCH{!sow || state == S_WINDOW}};

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pend[c]) begin
        grant_vld = 1'b1;
        grant_ch  = 5'(c);
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = rd_bit && !rd_prev && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push       = grant_vld && (!fifo_full || pop);
  assign grant_mask = NCH'(push) << grant_ch;

  // Stage p3: pending latch; an edge on an already pending channel is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      pend         <= '0;
      overflow_cnt <= '0;
      for (int c = 0; c < NCH; c++) pend_ts[c] <= '0;
    end else begin
      pend         <= (pend & ~grant_mask) | (cap & ~pend);
      overflow_cnt <= sat_add(overflow_cnt, count_ones(cap & pend));
      for (int c = 0; c < NCH; c++)
        if (cap[c] && !pend[c]) pend_ts[c] <= ts_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant_ch, pend_ts[grant_ch]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_dout  = fifo_empty ? 32'd0 : mem[rd_ptr];
  assign fifo_count = 8'(count);

endmodule

// File: tb/tb_qpix_top.sv
// Randomised scoreboard bench for qpix_top: a timing-level model predicts each
// event word, a monitor drains the FIFO and compares in order.
module tb_qpix_top;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          resetn;
  logic [15:0]   lvds;
  logic          pad;
  logic [2047:0] reg_rw;
  logic [31:0]   ctrl0, w7, w9;
  logic          rd_mon, rd_stim;
  logic [31:0]   fifo_dout;
  logic          fifo_empty, fifo_full, window_active;
  logic [7:0]    fifo_count;
  logic [15:0]   overflow_cnt;

  always_comb begin
    reg_rw            = '0;
    reg_rw[31:0]      = ctrl0;
    reg_rw[6*32]      = rd_mon | rd_stim;
    reg_rw[7*32 +: 32] = w7;
    reg_rw[9*32 +: 32] = w9;
  end

  qpix_top #(.FIFO_DEPTH(128), .TS_W(27)) dut (
    .clk(clk), .resetn(resetn), .oLVDS(lvds), .opad2_deltaT(pad), .reg_rw(reg_rw),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .window_active(window_active), .overflow_cnt(overflow_cnt)
  );

  longint gcyc = 0, rst_mark = 0;
  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (!resetn || ctrl0[0]) rst_mark <= gcyc + 1;
  end

  int          checks = 0, errors = 0;
  logic [31:0] q[$];
  int          exp_ovf = 0;
  bit          sow_m = 0;
  longint      win_s = 0, win_l = 0;
  int          mon_allow = 0, pops_done = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Event word expected for a rise whose detect cycle follows posedge d
  function automatic void expect_det(input logic [16:0] mask, input longint d);
    longint t;
    for (int c = 0; c < 17; c++) begin
      if (mask[c] && (!sow_m || (d >= win_s && d < win_s + win_l))) begin
        t = sow_m ? d - win_s : d - rst_mark;
        q.push_back({5'(c), 27'(t)});
      end
    end
  endfunction

  task automatic pulse(input logic [16:0] mask, input int hi, input int lo);
    {pad, lvds} = mask;
    expect_det(mask, gcyc + 2);
    tick(hi);
    {pad, lvds} = '0;
    tick(lo);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dout"},  fifo_dout, 0);
    chk({tag, "_empty"}, fifo_empty, 1);
    chk({tag, "_full"},  fifo_full, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_wact"},  window_active, 0);
    chk({tag, "_ovf"},   overflow_cnt, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    mon_allow = 1000000;
    while ((q.size() != 0 || !fifo_empty || rd_mon) && n < 5000) begin
      tick();
      n++;
    end
    tick(4);
    chk({tag, "_queue_left"}, q.size(), 0);
    chk({tag, "_fifo_empty"}, fifo_empty, 1);
  endtask

  task automatic count_window(input int n, output longint first, output int hi);
    first = -1;
    hi    = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (window_active) begin
        if (hi == 0) first = gcyc;
        hi++;
      end
    end
    #11;
  endtask

  initial begin
    logic [31:0] exp_w;
    rd_mon = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_mon) rd_mon = 1'b0;
      else if (pops_done < mon_allow && resetn && !fifo_empty) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry actual=0x%08h required=none", fifo_dout);
        end else begin
          exp_w = q.pop_front();
          if (fifo_dout !== exp_w) begin
            errors++;
            $display("FAIL fifo_head actual=ch%0d ts=%0d required=ch%0d ts=%0d",
                     fifo_dout[31:27], fifo_dout[26:0], exp_w[31:27], exp_w[26:0]);
          end
        end
        pops_done++;
        rd_mon = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    longint t0, first;
    int     hi;
    resetn = 1'b0; ctrl0 = '0; w7 = '0; w9 = '0;
    lvds = '0; pad = 1'b0; rd_stim = 1'b0;
    tick(5);
    check_reset("hwrst");
    resetn = 1'b1;
    tick(3);

    // Free-running timestamps, random simultaneous edges
    mon_allow = 1000000;
    for (int it = 0; it < 25; it++) begin
      logic [16:0] m;
      m = (it == 0) ? 17'h10024 : 17'($urandom);
      pulse(m, 2, 18 + int'($urandom_range(0, 5)));
    end
    wait_drain("random");

    for (int i = 0; i < 3; i++) begin
      rd_stim = 1'b1; tick();
      rd_stim = 1'b0; tick();
    end
    chk("empty_pop_count", fifo_count, 0);
    chk("empty_pop_empty", fifo_empty, 1);
    chk("empty_pop_dout",  fifo_dout, 0);

    // Fill the FIFO, then overflow a pending channel
    mon_allow = pops_done;
    for (int r = 0; r < 8; r++) pulse(17'h0FFFF, 2, 20);
    tick(5);
    chk("fill_full",  fifo_full, 1);
    chk("fill_count", fifo_count, 128);
    lvds[3] = 1'b1; expect_det(17'h8, gcyc + 2); tick(2);
    lvds[3] = 1'b0; tick(2);
    lvds[3] = 1'b1; exp_ovf++; tick(2);
    lvds[3] = 1'b0; tick(2);
    lvds[3] = 1'b1; exp_ovf++; tick(2);
    lvds[3] = 1'b0; tick(6);
    chk("ovf_count",     overflow_cnt, exp_ovf);
    chk("ovf_fifo_cnt",  fifo_count, 128);
    mon_allow = pops_done + 1;
    tick(6);
    chk("refill_count", fifo_count, 128);
    chk("refill_full",  fifo_full, 1);
    wait_drain("full");
    chk("ovf_kept", overflow_cnt, exp_ovf);

    // Soft reset with entries and overflow present
    mon_allow = pops_done;
    pulse(17'h00013, 2, 20);
    chk("pre_soft_count", fifo_count, 3);
    ctrl0[0] = 1'b1;
    tick(25);
    q.delete();
    check_reset("softrst");
    ctrl0[0] = 1'b0;
    tick(3);

    // Window mode: edges outside the window are not captured
    mon_allow = 1000000;
    w7 = 32'd100; w9 = 32'h80000064;
    sow_m = 1; win_s = 0; win_l = 0;
    pulse(17'h80, 2, 10);
    ctrl0[15] = 1'b1;
    t0 = gcyc; win_s = t0 + 101; win_l = 100;
    count_window(260, first, hi);
    chk("win_start", first, t0 + 101);
    chk("win_len",   hi, 100);
    count_window(200, first, hi);
    chk("win_no_retrigger", hi, 0);
    pulse(17'h200, 2, 10);
    ctrl0[15] = 1'b0;
    tick(2);

    w7 = 32'd2000; w9 = 32'h80000032;
    ctrl0[15] = 1'b1;
    t0 = gcyc; win_s = t0 + 51; win_l = 2000;
    for (int i = 0; i < 11; i++) begin
      while (gcyc < t0 + 60 + 202 * i) tick();
      pulse(17'h1, 3, 0);
    end
    ctrl0[15] = 1'b0;
    wait_drain("longrun");

    // Zero wait, zero width: one-cycle window catching an edge at ts 0
    w7 = 32'd0; w9 = 32'h80000000;
    lvds[4] = 1'b1;
    t0 = gcyc;
    tick();
    ctrl0[15] = 1'b1;
    win_s = gcyc + 1; win_l = 1;
    expect_det(17'h10, t0 + 2);
    t0 = gcyc;
    count_window(10, first, hi);
    chk("win0_start", first, t0 + 1);
    chk("win0_len",   hi, 1);
    lvds[4] = 1'b0;
    wait_drain("win0");

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
